cmp_unit_pipe: RTL and testbench
================================

// Module: cmp_unit_pipe
// PURPOSE
//  Parametrised successor to the ALU compare unit: a PIPE_STAGES-deep pipelined comparator.
//  Adds signed/unsigned mode, 8 functions (incl. NE/GE/MIN/MAX) and a 1-bit boolean result.
//  A running min/max/count tracker on operand A supports reduction workloads.
//  Sits beside the arithmetic/logic/shift units inside the signed ALU; fed by the ALU decoder.
// PARAMETERS
//  DATA_WIDTH   16  operand width of A, B
//  OUT_WIDTH    16  CMP_OUT width; must be >= DATA_WIDTH
//  PIPE_STAGES  2   input-to-output latency in cycles; must be >= 1
//  CNT_WIDTH    8   width of SAMPLE_CNT (saturating)
// PORTS
//  CLK          in   1           clock, rising edge
//  RST          in   1           synchronous reset, active-high
//  A            in   DATA_WIDTH  operand A
//  B            in   DATA_WIDTH  operand B
//  CMP_Enable   in   1           input valid; operands/select sampled when high
//  CMP_FUN_SEL  in   3           function select (see BEHAVIOUR)
//  SIGNED_MODE  in   1           1 = two's-complement compare, 0 = unsigned
//  ACC_CLR      in   1           clear running tracker
//  CMP_OUT      out  OUT_WIDTH   compare code / selected operand
//  CMP_Result   out  1           predicate outcome
//  CMP_Flag     out  1           output valid, CMP_Enable delayed PIPE_STAGES cycles
//  RUN_MIN      out  DATA_WIDTH  min of A over tracked samples
//  RUN_MAX      out  DATA_WIDTH  max of A over tracked samples
//  SAMPLE_CNT   out  CNT_WIDTH   number of tracked samples, saturates at all-ones
//  RUN_VALID    out  1           tracker holds >= 1 sample
// BEHAVIOUR
//  Reset: all outputs and all pipeline registers 0 on first CLK edge with RST=1. RST has priority.
//  Functions (CMP_OUT if true / if false; CMP_Result = predicate):
//  - 000 NOP: CMP_OUT=0, Result=0.
//  - 001 EQ:  1 / 0.
//  - 010 GT:  2 / 0 (legacy codes).
//  - 011 LT:  3 / 0 (legacy codes).
//  - 100 NE:  4 / 0.
//  - 101 GE:  5 / 0.
//  - 110 MIN: CMP_OUT = min(A,B), extended to OUT_WIDTH; Result=1 iff A<=B (A selected).
//  - 111 MAX: CMP_OUT = max(A,B), extended to OUT_WIDTH; Result=1 iff A>=B (A selected).
//  Extension for MIN/MAX: sign-extend if SIGNED_MODE=1, else zero-extend.
//  Operands, select and mode are captured together in stage 1; later changes do not affect in-flight ops.
//  Pipeline: an op accepted at edge N is visible after edge N+PIPE_STAGES-1.
//  - PIPE_STAGES=1: registered next edge.
//  - Issue rate: one op per cycle; no backpressure.
//  - CMP_Flag mirrors the accepted CMP_Enable through the same delay.
//  Empty slots (CMP_Enable=0) emit CMP_OUT=0, Result=0, Flag=0.
//  Reset mid-operation flushes every stage; CMP_Flag stays 0 until new ops traverse the pipe.
//  Tracker (1-cycle update, independent of PIPE_STAGES), per edge:
//  - ACC_CLR=1, CMP_Enable=0: RUN_MIN=RUN_MAX=0, SAMPLE_CNT=0, RUN_VALID=0.
//  - ACC_CLR=1, CMP_Enable=1: clear, then load sample -> MIN=MAX=A, CNT=1, VALID=1.
//  - CMP_Enable=1, RUN_VALID=0: MIN=MAX=A, CNT=1, VALID=1.
//  - CMP_Enable=1, RUN_VALID=1: MIN/MAX update using current SIGNED_MODE; CNT+1, saturating.
//  - Otherwise hold.
//  Tracked samples include NOP ops; tracker ignores B.
// TESTING
//  - Reset: RST=1 two cycles mid-stream -> all outputs 0, CMP_Flag 0 for PIPE_STAGES cycles after release.
//  - Signed vs unsigned (DW=16): A=16'hFFFF, B=16'h0001, sel=010.
//    SIGNED_MODE=1 -> CMP_OUT=0, Result=0. SIGNED_MODE=0 -> CMP_OUT=2, Result=1.
//  - Latency/throughput (PIPE_STAGES=3): back-to-back EQ(5,5), LT(2,9), NE(7,7) on cycles 0..2.
//    -> cycles 3..5 give OUT=1/R=1, OUT=3/R=1, OUT=0/R=0; Flag high exactly 3 cycles.
//  - MIN/MAX extension (OUT_WIDTH=32), A=16'h8000, B=16'h0010:
//    MIN signed -> 32'hFFFF8000, Result=1. MAX unsigned -> 32'h00008000, Result=1.
//  - Tracker: signed samples A=5, -3, 12, then ACC_CLR with enable A=7.
//    -> MIN=-3, MAX=12, CNT=3; then MIN=MAX=7, CNT=1, VALID=1.
//  - Saturation (CNT_WIDTH=4): 20 enabled samples -> SAMPLE_CNT holds 4'hF, no wrap.

Source files
------------

// File: rtl/cmp_unit_pipe.sv
// cmp_unit_pipe
//   Pipelined comparator for the signed ALU. Each accepted op (CMP_Enable=1)
//   is evaluated on the cycle it is presented and then travels through
//   PIPE_STAGES registers together with its valid bit, so results appear
//   PIPE_STAGES cycles after issue at a rate of one op per cycle.
//   A separate running tracker keeps min/max/count of operand A with a
//   single-cycle update, independent of the pipeline depth.
//
// Ports
//   CLK, RST      clock (rising edge), synchronous active-high reset
//   A, B          operands (DATA_WIDTH)
//   CMP_Enable    input valid; operands, select and mode sampled together
//   CMP_FUN_SEL   function: NOP/EQ/GT/LT/NE/GE/MIN/MAX
//   SIGNED_MODE   1 = two's-complement compare, 0 = unsigned
//   ACC_CLR       clear the running tracker (a same-cycle sample is loaded)
//   CMP_OUT       compare code, or selected operand for MIN/MAX (OUT_WIDTH)
//   CMP_Result    predicate outcome
//   CMP_Flag      output valid
//   RUN_MIN/MAX   running min/max of A over tracked samples
//   SAMPLE_CNT    tracked sample count, saturating at all-ones
//   RUN_VALID     tracker holds at least one sample
module cmp_unit_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  CMP_Enable,
  input  logic [2:0]            CMP_FUN_SEL,
  input  logic                  SIGNED_MODE,
  input  logic                  ACC_CLR,
  output logic [OUT_WIDTH-1:0]  CMP_OUT,
  output logic                  CMP_Result,
  output logic                  CMP_Flag,
  output logic [DATA_WIDTH-1:0] RUN_MIN,
  output logic [DATA_WIDTH-1:0] RUN_MAX,
  output logic [CNT_WIDTH-1:0]  SAMPLE_CNT,
  output logic                  RUN_VALID
);

  localparam logic [2:0] FN_NOP = 3'b000;
  localparam logic [2:0] FN_EQ  = 3'b001;
  localparam logic [2:0] FN_GT  = 3'b010;
  localparam logic [2:0] FN_LT  = 3'b011;
  localparam logic [2:0] FN_NE  = 3'b100;
  localparam logic [2:0] FN_GE  = 3'b101;
  localparam logic [2:0] FN_MIN = 3'b110;
  localparam logic [2:0] FN_MAX = 3'b111;

  // a < b under the selected interpretation
  function automatic logic a_lt_b(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b,
                                  input logic                  sgn);
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    sa = a;
    sb = b;
    if (sgn) return (sa < sb);
    else     return (a < b);
  endfunction

  // Widen a selected operand: sign-extend in signed mode, zero-extend otherwise
  function automatic logic [OUT_WIDTH-1:0] ext_op(input logic [DATA_WIDTH-1:0] x,
                                                  input logic                  sgn);
    logic signed [DATA_WIDTH-1:0] sx;
    sx = x;
    if (sgn) return OUT_WIDTH'(sx);
    else     return OUT_WIDTH'(x);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) return c;
    else    return c + CNT_WIDTH'(1);
  endfunction

  // ---- stage p0: evaluate the op presented this cycle ----
  logic                 lt_p0, gt_p0, eq_p0;
  logic [OUT_WIDTH-1:0] cmp_out_d;
  logic                 res_d;

  always_comb begin
    eq_p0     = (A == B);
    lt_p0     = a_lt_b(A, B, SIGNED_MODE);
    gt_p0     = a_lt_b(B, A, SIGNED_MODE);
    cmp_out_d = '0;
    res_d     = 1'b0;
    if (CMP_Enable) begin
      unique case (CMP_FUN_SEL)
        FN_NOP: res_d = 1'b0;
        FN_EQ:  res_d = eq_p0;
        FN_GT:  res_d = gt_p0;
        FN_LT:  res_d = lt_p0;
        FN_NE:  res_d = !eq_p0;
        FN_GE:  res_d = !lt_p0;
        FN_MIN: res_d = !gt_p0;  // A <= B selects A
        FN_MAX: res_d = !lt_p0;  // A >= B selects A
        default: res_d = 1'b0;
      endcase
      unique case (CMP_FUN_SEL)
        FN_EQ:  cmp_out_d = res_d ? OUT_WIDTH'(1) : '0;
        FN_GT:  cmp_out_d = res_d ? OUT_WIDTH'(2) : '0;
        FN_LT:  cmp_out_d = res_d ? OUT_WIDTH'(3) : '0;
        FN_NE:  cmp_out_d = res_d ? OUT_WIDTH'(4) : '0;
        FN_GE:  cmp_out_d = res_d ? OUT_WIDTH'(5) : '0;
        FN_MIN: cmp_out_d = ext_op(res_d ? A : B, SIGNED_MODE);
        FN_MAX: cmp_out_d = ext_op(res_d ? A : B, SIGNED_MODE);
        default: cmp_out_d = '0;
      endcase
    end
  end

  // ---- stages p1..pN: delay line carrying result with its valid ----
  logic [OUT_WIDTH-1:0] cmp_out_q [PIPE_STAGES];
  logic                 res_q     [PIPE_STAGES];
  logic                 vld_q     [PIPE_STAGES];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        cmp_out_q[i] <= '0;
        res_q[i]     <= 1'b0;
        vld_q[i]     <= 1'b0;
      end
    end else begin
      cmp_out_q[0] <= cmp_out_d;
      res_q[0]     <= res_d;
      vld_q[0]     <= CMP_Enable;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        cmp_out_q[i] <= cmp_out_q[i-1];
        res_q[i]     <= res_q[i-1];
        vld_q[i]     <= vld_q[i-1];
      end
    end
  end

  assign CMP_OUT    = cmp_out_q[PIPE_STAGES-1];
  assign CMP_Result = res_q[PIPE_STAGES-1];
  assign CMP_Flag   = vld_q[PIPE_STAGES-1];

  // ---- running tracker: single-cycle update ----
  logic [DATA_WIDTH-1:0] min_q, min_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  tvld_q, tvld_d;

  always_comb begin
    min_d  = min_q;
    max_d  = max_q;
    cnt_d  = cnt_q;
    tvld_d = tvld_q;
    if (ACC_CLR || (CMP_Enable && !tvld_q)) begin
      // Clear, then load the same-cycle sample if one is present
      min_d  = CMP_Enable ? A : '0;
      max_d  = CMP_Enable ? A : '0;
      cnt_d  = CMP_Enable ? CNT_WIDTH'(1) : '0;
      tvld_d = CMP_Enable;
    end else if (CMP_Enable) begin
      if (a_lt_b(A, min_q, SIGNED_MODE)) min_d = A;
      if (a_lt_b(max_q, A, SIGNED_MODE)) max_d = A;
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      min_q  <= '0;
      max_q  <= '0;
      cnt_q  <= '0;
      tvld_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      cnt_q  <= cnt_d;
      tvld_q <= tvld_d;
    end
  end

  assign RUN_MIN    = min_q;
  assign RUN_MAX    = max_q;
  assign SAMPLE_CNT = cnt_q;
  assign RUN_VALID  = tvld_q;

endmodule

// File: tb/tb_cmp_unit_pipe.sv
module tb_cmp_unit_pipe;
  localparam int DW = 16;
  localparam int OW = 32;
  localparam int PS = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a, b;
  logic          en;
  logic [2:0]    sel;
  logic          smode;
  logic          aclr;
  logic [OW-1:0] cmp_out;
  logic          cmp_res;
  logic          cmp_flag;
  logic [DW-1:0] run_min, run_max;
  logic [CW-1:0] cnt;
  logic          run_valid;

  int total = 0;
  int bad   = 0;
  logic [OW:0] sb[$];   // {result, cmp_out}

  cmp_unit_pipe #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .PIPE_STAGES(PS), .CNT_WIDTH(CW)) dut (
    .CLK(clk), .RST(rst), .A(a), .B(b), .CMP_Enable(en), .CMP_FUN_SEL(sel),
    .SIGNED_MODE(smode), .ACC_CLR(aclr), .CMP_OUT(cmp_out), .CMP_Result(cmp_res),
    .CMP_Flag(cmp_flag), .RUN_MIN(run_min), .RUN_MAX(run_max), .SAMPLE_CNT(cnt),
    .RUN_VALID(run_valid));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one enabled op for one edge and record its expected response
  task automatic issue(input logic [2:0] s, input logic m, input logic [DW-1:0] av,
                       input logic [DW-1:0] bv, input logic clr,
                       input logic [OW-1:0] exp_out, input logic exp_res);
    sel = s; smode = m; a = av; b = bv; aclr = clr; en = 1'b1;
    sb.push_back({exp_res, exp_out});
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic clr);
    en = 1'b0; aclr = clr; a = '0; b = '0; sel = 3'b000;
    @(posedge clk); #1;
  endtask

  task automatic chk_trk(input string name, input logic [DW-1:0] mn, input logic [DW-1:0] mx,
                         input logic [CW-1:0] c, input logic v);
    chk({name, "_min"}, 64'(run_min), 64'(mn));
    chk({name, "_max"}, 64'(run_max), 64'(mx));
    chk({name, "_cnt"}, 64'(cnt), 64'(c));
    chk({name, "_vld"}, 64'(run_valid), 64'(v));
  endtask

  // Monitor: pop one expectation per valid output, idle slots must be zero
  always @(negedge clk) begin
    if (!rst) begin
      if (cmp_flag) begin
        if (sb.size() == 0) begin
          chk("unexpected_flag", 64'(cmp_flag), 64'd0);
        end else begin
          logic [OW:0] e;
          e = sb.pop_front();
          chk("cmp_out", 64'(cmp_out), 64'(e[OW-1:0]));
          chk("cmp_res", 64'(cmp_res), 64'(e[OW]));
        end
      end else begin
        chk("idle_slot", 64'({cmp_res, cmp_out}), 64'd0);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; aclr = 1'b0; a = '0; b = '0; sel = '0; smode = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out", 64'({cmp_flag, cmp_res, cmp_out}), 64'd0);
    chk_trk("rst", 16'h0, 16'h0, 4'h0, 1'b0);
    rst = 1'b0;

    // Latency: captured at edge E, visible only after edge E+2
    issue(3'b001, 1'b1, 16'd5, 16'd5, 1'b0, 32'd1, 1'b1);
    chk("lat_e0", 64'(cmp_flag), 64'd0);
    idle(1'b0);
    chk("lat_e1", 64'(cmp_flag), 64'd0);
    idle(1'b0);
    chk("lat_e2", 64'(cmp_flag), 64'd1);
    idle(1'b0);
    idle(1'b0);

    // Signed vs unsigned GT
    issue(3'b010, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 32'd0, 1'b0);
    issue(3'b010, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 32'd2, 1'b1);
    // Back-to-back throughput
    issue(3'b001, 1'b1, 16'd5, 16'd5, 1'b0, 32'd1, 1'b1);
    issue(3'b011, 1'b1, 16'd2, 16'd9, 1'b0, 32'd3, 1'b1);
    issue(3'b100, 1'b1, 16'd7, 16'd7, 1'b0, 32'd0, 1'b0);
    // Other predicates
    issue(3'b100, 1'b0, 16'd7, 16'd8, 1'b0, 32'd4, 1'b1);
    issue(3'b101, 1'b0, 16'd3, 16'd3, 1'b0, 32'd5, 1'b1);
    issue(3'b101, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 32'd0, 1'b0);
    issue(3'b011, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 32'd0, 1'b0);
    issue(3'b000, 1'b0, 16'h1234, 16'h1234, 1'b0, 32'd0, 1'b0);
    // MIN/MAX with extension
    issue(3'b110, 1'b1, 16'h8000, 16'h0010, 1'b0, 32'hFFFF8000, 1'b1);
    issue(3'b111, 1'b0, 16'h8000, 16'h0010, 1'b0, 32'h00008000, 1'b1);
    issue(3'b110, 1'b0, 16'h8000, 16'h0010, 1'b0, 32'h00000010, 1'b0);
    issue(3'b111, 1'b1, 16'h8000, 16'h0010, 1'b0, 32'h00000010, 1'b0);
    issue(3'b111, 1'b1, 16'hFFF0, 16'hFFF0, 1'b0, 32'hFFFFFFF0, 1'b1);
    idle(1'b0);

    // Tracker: signed 5, -3, 12 then clear+load 7, then plain clear
    idle(1'b1);
    chk_trk("trk_clr0", 16'h0, 16'h0, 4'h0, 1'b0);
    issue(3'b000, 1'b1, 16'd5,    16'h7FFF, 1'b0, 32'd0, 1'b0);
    chk_trk("trk_s1", 16'd5, 16'd5, 4'd1, 1'b1);
    issue(3'b000, 1'b1, 16'hFFFD, 16'h0000, 1'b0, 32'd0, 1'b0);
    issue(3'b000, 1'b1, 16'd12,   16'h8000, 1'b0, 32'd0, 1'b0);
    chk_trk("trk_s3", 16'hFFFD, 16'd12, 4'd3, 1'b1);
    idle(1'b0);
    chk_trk("trk_hold", 16'hFFFD, 16'd12, 4'd3, 1'b1);
    issue(3'b000, 1'b1, 16'd7, 16'd0, 1'b1, 32'd0, 1'b0);
    chk_trk("trk_clrload", 16'd7, 16'd7, 4'd1, 1'b1);
    idle(1'b1);
    chk_trk("trk_clr1", 16'h0, 16'h0, 4'h0, 1'b0);

    // Saturation: 20 samples into a 4-bit counter
    for (int i = 1; i <= 20; i++) begin
      issue(3'b000, 1'b0, 16'(i), 16'd0, 1'b0, 32'd0, 1'b0);
      if (i == 14) chk("sat_14", 64'(cnt), 64'hE);
      if (i == 15) chk("sat_15", 64'(cnt), 64'hF);
    end
    chk_trk("sat_20", 16'd1, 16'd20, 4'hF, 1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Mid-stream reset: two ops in flight, enable held high during reset
    issue(3'b001, 1'b0, 16'd1, 16'd1, 1'b0, 32'd1, 1'b1);
    issue(3'b001, 1'b0, 16'd2, 16'd2, 1'b0, 32'd1, 1'b1);
    sb.delete();
    rst = 1'b1; en = 1'b1; sel = 3'b001; a = 16'd3; b = 16'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mrst_out", 64'({cmp_flag, cmp_res, cmp_out}), 64'd0);
    chk_trk("mrst", 16'h0, 16'h0, 4'h0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < PS; i++) begin
      idle(1'b0);
      chk("mrst_flag", 64'(cmp_flag), 64'd0);
    end
    issue(3'b011, 1'b1, 16'hFFFE, 16'h0001, 1'b0, 32'd3, 1'b1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b0);
    chk("drain", 64'(sb.size()), 64'd0);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
